// File: rtl/sha_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial SHA-256 timing logic.
package sha_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  localparam int W_WORD_DEF   = 32;
  localparam int N_ROUNDS_DEF = 64;

  // Index width for a counter over n values; never below one bit so that
  // degenerate sizes (n == 1) still produce a legal vector.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = width_of(W_WORD_DEF);
  localparam int RND_W = width_of(N_ROUNDS_DEF);

endpackage

// File: rtl/serial_round_sequencer_bclk_gen.sv
// Bit-clock generator: phase counter that toggles bclk every HALF clk
// cycles, with a hold input honoured only at the start of a low half and
// strobes marking the end of each half-period and of each full bit.
module bclk_gen
  import sha_serial_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_hold,
  input  logic i_drain,
  output logic o_bclk,
  output logic o_half_end,
  output logic o_bit_end
);

  localparam int             PH_W    = width_of(HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  logic [PH_W-1:0] r_ph;
  logic            r_bclk;
  logic            w_hold;

  // Hold only bites in the first phase slot, so a started half always completes.
  assign w_hold     = i_hold && (r_ph == '0);
  assign o_half_end = i_run && !w_hold && (r_ph == PH_LAST);
  assign o_bit_end  = o_half_end && r_bclk;
  assign o_bclk     = r_bclk;

  // Phase counter and bclk toggle; bclk is held low while idle or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph   <= '0;
      r_bclk <= 1'b0;
    end else if (!i_run) begin
      r_ph   <= '0;
      r_bclk <= 1'b0;
    end else if (w_hold) begin
      r_ph   <= r_ph;
    end else if (r_ph == PH_LAST) begin
      r_ph <= '0;
      if (!i_drain) r_bclk <= ~r_bclk;
    end else begin
      r_ph <= r_ph + 1'b1;
    end
  end

endmodule

// File: rtl/serial_round_sequencer.sv
// Master timing controller for the bit-serial SHA-256 datapath: drives the
// shared bit clock, the bit index within a word and the round index, and
// hands a start/busy/done handshake to the message/hash control.
module serial_round_sequencer
  import sha_serial_pkg::*;
#(
  parameter int W_WORD   = W_WORD_DEF,
  parameter int N_ROUNDS = N_ROUNDS_DEF,
  parameter int HALF     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            pause,
  output logic                            bclk,
  output logic [width_of(W_WORD)-1:0]     counter,
  output logic [width_of(N_ROUNDS)-1:0]   round,
  output logic                            word_first,
  output logic                            word_last,
  output logic                            round_last,
  output logic                            busy,
  output logic                            done
);

  localparam int               CW       = width_of(W_WORD);
  localparam int               RW       = width_of(N_ROUNDS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(W_WORD - 1);
  localparam logic [RW-1:0]    RND_LAST = RW'(N_ROUNDS - 1);

  seq_state_t    r_state, w_state_n;
  logic [CW-1:0] r_cnt,   w_cnt_n;
  logic [RW-1:0] r_rnd,   w_rnd_n;
  logic          r_busy,  w_busy_n;
  logic          r_done,  w_done_n;

  logic w_run;
  logic w_hold;
  logic w_drain;
  logic w_bclk;
  logic w_half_end;
  logic w_bit_end;

  assign w_run   = (r_state != IDLE);
  assign w_hold  = pause && (r_state == LO);
  assign w_drain = (r_state == DRAIN);

  bclk_gen #(
    .HALF (HALF)
  ) u_bclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .i_hold     (w_hold),
    .i_drain    (w_drain),
    .o_bclk     (w_bclk),
    .o_half_end (w_half_end),
    .o_bit_end  (w_bit_end)
  );

  // Next-state decode: counter only moves on the bclk fall so it is stable
  // across every rising edge that consumers record on.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rnd_n   = r_rnd;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = LO;
          w_busy_n  = 1'b1;
          w_cnt_n   = '0;
          w_rnd_n   = '0;
        end
      end
      LO: begin
        if (w_half_end) w_state_n = HI;
      end
      HI: begin
        if (w_bit_end) begin
          if (r_cnt != CNT_LAST) begin
            w_cnt_n   = r_cnt + 1'b1;
            w_state_n = LO;
          end else if (r_rnd != RND_LAST) begin
            w_cnt_n   = '0;
            w_rnd_n   = r_rnd + 1'b1;
            w_state_n = LO;
          end else begin
            w_cnt_n   = '0;
            w_state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_half_end) begin
          w_state_n = IDLE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_rnd_n   = '0;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State and sequencing registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rnd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rnd   <= w_rnd_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign bclk       = w_bclk;
  assign counter    = r_cnt;
  assign round      = r_rnd;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_first = r_busy && (r_cnt == '0);
  assign word_last  = r_busy && (r_cnt == CNT_LAST);
  assign round_last = r_busy && (r_rnd == RND_LAST);

endmodule

// File: tb/tb_serial_round_sequencer.sv
// Directed bench for serial_round_sequencer: small (4/2/1), mid (4/2/2) and
// default (32/64/2) instances driven from one clock.
module tb_serial_round_sequencer;

  logic clk;
  logic rst_n;

  // Small instance: W_WORD=4, N_ROUNDS=2, HALF=1
  logic       s_start, s_pause, s_bclk, s_wf, s_wl, s_rl, s_busy, s_done;
  logic [1:0] s_cnt;
  logic [0:0] s_rnd;
  // Mid instance: W_WORD=4, N_ROUNDS=2, HALF=2
  logic       m_start, m_pause, m_bclk, m_wf, m_wl, m_rl, m_busy, m_done;
  logic [1:0] m_cnt;
  logic [0:0] m_rnd;
  // Default instance: 32/64/2
  logic       d_start, d_pause, d_bclk, d_wf, d_wl, d_rl, d_busy, d_done;
  logic [4:0] d_cnt;
  logic [5:0] d_rnd;

  int n_chk = 0;
  int n_err = 0;

  serial_round_sequencer #(.W_WORD(4), .N_ROUNDS(2), .HALF(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .pause(s_pause),
    .bclk(s_bclk), .counter(s_cnt), .round(s_rnd), .word_first(s_wf),
    .word_last(s_wl), .round_last(s_rl), .busy(s_busy), .done(s_done));

  serial_round_sequencer #(.W_WORD(4), .N_ROUNDS(2), .HALF(2)) u_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .pause(m_pause),
    .bclk(m_bclk), .counter(m_cnt), .round(m_rnd), .word_first(m_wf),
    .word_last(m_wl), .round_last(m_rl), .busy(m_busy), .done(m_done));

  serial_round_sequencer #(.W_WORD(32), .N_ROUNDS(64), .HALF(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .pause(d_pause),
    .bclk(d_bclk), .counter(d_cnt), .round(d_rnd), .word_first(d_wf),
    .word_last(d_wl), .round_last(d_rl), .busy(d_busy), .done(d_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {bclk, counter[1:0], round, busy, done, word_first, word_last, round_last}
  typedef struct packed {
    logic       start;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [8:0] s_out();
    return {s_bclk, s_cnt, s_rnd, s_busy, s_done, s_wf, s_wl, s_rl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_done(input int which);
    case (which)
      0:       return s_done;
      1:       return m_done;
      default: return d_done;
    endcase
  endfunction

  // Ticks until the selected instance shows done, bounded by 'bound' cycles.
  task automatic wait_done(input int which, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cur_done(which) && n < bound);
    if (!cur_done(which)) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_done[%0d]: no done within %0d cycles", which, bound);
    end
  endtask

  // Independent bit-count model of the default instance, checked on every
  // bclk rising edge.
  logic d_prev_bclk = 1'b0;
  logic d_prev_busy = 1'b0;
  int   d_rises     = 0;
  int   d_wl_rises  = 0;
  int   d_rl_rises  = 0;
  int   d_prev_cnt  = 0;

  always @(negedge clk) begin
    if (d_busy && !d_prev_busy) begin
      d_rises    = 0;
      d_wl_rises = 0;
      d_rl_rises = 0;
    end
    if (d_bclk && !d_prev_bclk) begin
      chk("d_rise_cnt", 32'(d_cnt), 32'(d_rises % 32));
      chk("d_rise_rnd", 32'(d_rnd), 32'(d_rises / 32));
      if (d_rises > 0) chk("d_rise_step", 32'(d_cnt), 32'((d_prev_cnt + 1) % 32));
      d_prev_cnt = int'(d_cnt);
      if (d_wl) d_wl_rises++;
      if (d_rl) d_rl_rises++;
      d_rises++;
    end
    d_prev_bclk = d_bclk;
    d_prev_busy = d_busy;
  end

  initial begin
    int n;
    int k;

    tbl[0]  = '{1'b1, 9'b0_00_0_1_0_1_0_0};
    tbl[1]  = '{1'b0, 9'b1_00_0_1_0_1_0_0};
    tbl[2]  = '{1'b0, 9'b0_01_0_1_0_0_0_0};
    tbl[3]  = '{1'b0, 9'b1_01_0_1_0_0_0_0};
    tbl[4]  = '{1'b0, 9'b0_10_0_1_0_0_0_0};
    tbl[5]  = '{1'b0, 9'b1_10_0_1_0_0_0_0};
    tbl[6]  = '{1'b0, 9'b0_11_0_1_0_0_1_0};
    tbl[7]  = '{1'b0, 9'b1_11_0_1_0_0_1_0};
    tbl[8]  = '{1'b0, 9'b0_00_1_1_0_1_0_1};
    tbl[9]  = '{1'b0, 9'b1_00_1_1_0_1_0_1};
    tbl[10] = '{1'b0, 9'b0_01_1_1_0_0_0_1};
    tbl[11] = '{1'b0, 9'b1_01_1_1_0_0_0_1};
    tbl[12] = '{1'b0, 9'b0_10_1_1_0_0_0_1};
    tbl[13] = '{1'b0, 9'b1_10_1_1_0_0_0_1};
    tbl[14] = '{1'b0, 9'b0_11_1_1_0_0_1_1};
    tbl[15] = '{1'b0, 9'b1_11_1_1_0_0_1_1};
    tbl[16] = '{1'b0, 9'b0_00_1_1_0_1_0_1};
    tbl[17] = '{1'b0, 9'b0_00_0_0_1_0_0_0};
    tbl[18] = '{1'b0, 9'b0_00_0_0_0_0_0_0};

    rst_n   = 1'b0;
    s_start = 1'b0; s_pause = 1'b0;
    m_start = 1'b0; m_pause = 1'b0;
    d_start = 1'b0; d_pause = 1'b0;
    tick(); tick();
    chk("reset_s", 32'(s_out()), 32'd0);
    chk("reset_m", 32'({m_bclk, m_cnt, m_rnd, m_busy, m_done, m_wf, m_wl, m_rl}), 32'd0);
    chk("reset_d", 32'({d_bclk, d_cnt, d_rnd, d_busy, d_done, d_wf, d_wl, d_rl}), 32'd0);
    rst_n = 1'b1;
    s_pause = 1'b1;  // pause in IDLE has no effect
    tick(); tick();
    chk("idle_s", 32'(s_out()), 32'd0);
    s_pause = 1'b0;

    // Full small run, cycle by cycle from the start edge.
    for (int i = 0; i < 19; i++) begin
      s_start = tbl[i].start;
      tick();
      chk($sformatf("tbl[%0d]", i), 32'(s_out()), 32'(tbl[i].exp));
    end
    s_start = 1'b0;

    // Pause at the bit boundary where counter becomes 2: 10 cycles of hold.
    s_start = 1'b1; tick(); s_start = 1'b0; k = 0;
    for (int i = 0; i < 4; i++) begin tick(); k++; end
    chk("pause_entry", 32'({s_bclk, s_cnt}), 32'({1'b0, 2'd2}));
    s_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); k++;
      chk($sformatf("pause_hold[%0d]", i), 32'({s_bclk, s_cnt, s_busy}), 32'({1'b0, 2'd2, 1'b1}));
    end
    s_pause = 1'b0;
    tick(); k++;
    chk("pause_release", 32'({s_bclk, s_cnt}), 32'({1'b1, 2'd2}));
    wait_done(0, 100, n); k += n;
    chk("pause_done_k", 32'(k), 32'd27);
    tick();

    // Pause held through a HI half (mid instance) must not stretch bclk.
    m_start = 1'b1; tick(); m_start = 1'b0; k = 0;
    tick(); k++;
    tick(); k++;
    chk("mid_first_rise", 32'(m_bclk), 32'd1);
    m_pause = 1'b1;
    tick(); k++;
    chk("mid_hi_hold", 32'(m_bclk), 32'd1);
    m_pause = 1'b0;
    tick(); k++;
    chk("mid_hi_fall", 32'({m_bclk, m_cnt}), 32'({1'b0, 2'd1}));
    wait_done(1, 100, n); k += n;
    chk("mid_done_k", 32'(k), 32'd34);
    tick();

    // start while busy is ignored; start in the done cycle launches a new run.
    s_start = 1'b1; tick(); s_start = 1'b0; k = 0;
    for (int i = 0; i < 4; i++) begin tick(); k++; end
    s_start = 1'b1; tick(); k++; s_start = 1'b0;
    chk("restart_ignored", 32'({s_bclk, s_cnt, s_rnd, s_busy}), 32'({1'b1, 2'd2, 1'b0, 1'b1}));
    wait_done(0, 100, n); k += n;
    chk("restart_done_k", 32'(k), 32'd17);
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("redo_accept", 32'({s_busy, s_done, s_bclk, s_cnt}), 32'({1'b1, 1'b0, 1'b0, 2'd0}));
    tick();
    chk("redo_rise", 32'(s_bclk), 32'd1);
    k = 1;
    wait_done(0, 100, n); k += n;
    chk("redo_done_k", 32'(k), 32'd17);
    tick();

    // Asynchronous reset while HI at round 1, counter 3.
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("pre_reset", 32'({s_bclk, s_cnt, s_rnd}), 32'({1'b1, 2'd3, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({s_bclk, s_busy, s_cnt, s_rnd, s_done}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_reset_idle[%0d]", i), 32'({s_bclk, s_busy, s_done}), 32'd0);
    end

    // Default configuration full run.
    d_start = 1'b1; tick(); d_start = 1'b0; k = 0;
    chk("d_busy", 32'({d_busy, d_bclk}), 32'({1'b1, 1'b0}));
    wait_done(2, 9000, n); k += n;
    chk("d_done_k", 32'(k), 32'd8194);
    chk("d_busy_at_done", 32'(d_busy), 32'd0);
    tick();
    chk("d_done_pulse", 32'(d_done), 32'd0);
    chk("d_rises", 32'(d_rises), 32'd2048);
    chk("d_word_last", 32'(d_wl_rises), 32'd64);
    chk("d_round_last", 32'(d_rl_rises), 32'd32);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
